tdc_result_packer: RTL and testbench

- Downstream of the TDC core.
- Captures each finished measurement word (result bus qualified by the one-cycle done pulse) into a small synchronous FIFO.
- Serialises each word into a framed byte stream (sync byte + data bytes, MSB first) on a valid/ready interface for a UART or host link.
- Flags measurements lost to FIFO overflow.

---
 rtl/tdc_pack_pkg.sv | 19 +
 rtl/tdc_sync_fifo.sv | 50 +++++
 rtl/tdc_result_packer.sv | 159 +++++++++++++++
 tb/tb_tdc_result_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pack_pkg.sv
// Shared definitions for the TDC result packer: FSM encoding, default
// frame sync byte and the byte-count helper used to size the serialiser.
package tdc_pack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_SEQ  = 2'd3
    } state_t;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Number of whole bytes needed to carry a word of the given width.
    function automatic int nbytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// A push is accepted while full only when a pop happens in the same cycle.
module tdc_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iPush,
    input  logic [W-1:0]  iData,
    input  logic          iPop,
    output logic [W-1:0]  oData,
    output logic          oFull,
    output logic          oEmpty,
    output logic [LW-1:0] oLevel
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         we, re;

    assign oEmpty = (wr_ptr == rd_ptr);
    assign oFull  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign oLevel = wr_ptr - rd_ptr;
    assign oData  = mem[rd_ptr[AW-1:0]];

    assign re = iPop && !oEmpty;
    assign we = iPush && (!oFull || re);

    // Storage array; the head slot may be overwritten on a full push+pop
    // because the head is consumed at the same edge.
    always_ff @(posedge iClk) begin
        if (we) mem[wr_ptr[AW-1:0]] <= iData;
    end

    // Pointer update, wrapping naturally through the extra bit.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (we) wr_ptr <= wr_ptr + 1'b1;
            if (re) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/tdc_result_packer.sv
// TDC result packer: buffers finished measurement words and streams each
// one as a frame (sync byte, data bytes MSB first) over valid/ready.
// Optional build macro TDC_PACK_SEQ_EN appends an 8-bit push sequence
// number as the last byte of every frame.
module tdc_result_packer
    import tdc_pack_pkg::*;
#(
    parameter int         DATA_W     = 24,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] SYNC_BYTE  = DEF_SYNC_BYTE
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iDone,
    input  logic [DATA_W-1:0]             iTDC,
    input  logic                          iClrOvf,
    output logic [7:0]                    oByte,
    output logic                          oValid,
    input  logic                          iReady,
    output logic                          oOverflow,
    output logic [7:0]                    oDropCnt,
    output logic [$clog2(FIFO_DEPTH):0]   oLevel,
    output logic                          oBusy
);

    localparam int NB   = nbytes(DATA_W);
    localparam int SH_W = NB * 8;
`ifdef TDC_PACK_SEQ_EN
    localparam int FW = DATA_W + 8;
`else
    localparam int FW = DATA_W;
`endif

    state_t            state;
    logic              done_q;
    logic [DATA_W-1:0] tdc_q;
    logic              push, pop, drop, full, empty;
    logic [FW-1:0]     wdata, rdata;
    logic [SH_W-1:0]   sh;
    logic [2:0]        idx;

    // Register the core's result so the push decision sees stable data.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            done_q <= 1'b0;
            tdc_q  <= '0;
        end else begin
            done_q <= iDone;
            tdc_q  <= iTDC;
        end
    end

    assign pop  = (state == ST_IDLE) && !empty;
    assign push = done_q && (!full || pop);
    assign drop = done_q && !push;

`ifdef TDC_PACK_SEQ_EN
    logic [7:0] seq_cnt, seq_q;
    assign wdata = {seq_cnt, tdc_q};

    // Sequence number advances only on words that actually enter the FIFO.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)      seq_cnt <= 8'd0;
        else if (push) seq_cnt <= seq_cnt + 8'd1;
    end
`else
    assign wdata = tdc_q;
`endif

    tdc_sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (push),
        .iData  (wdata),
        .iPop   (pop),
        .oData  (rdata),
        .oFull  (full),
        .oEmpty (empty),
        .oLevel (oLevel)
    );

    // Sticky overflow and saturating drop count; a drop beats a clear.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oOverflow <= 1'b0;
            oDropCnt  <= 8'd0;
        end else if (iClrOvf) begin
            oOverflow <= drop;
            oDropCnt  <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            oOverflow <= 1'b1;
            if (oDropCnt != 8'hFF) oDropCnt <= oDropCnt + 8'd1;
        end
    end

    // Frame serialiser; oByte/oValid are registered and only change on a
    // handshake (or when a new frame is loaded from IDLE).
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state  <= ST_IDLE;
            sh     <= '0;
            idx    <= 3'd0;
            oByte  <= 8'd0;
            oValid <= 1'b0;
`ifdef TDC_PACK_SEQ_EN
            seq_q  <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        sh     <= SH_W'(rdata[DATA_W-1:0]);
                        idx    <= 3'(NB - 1);
                        oByte  <= SYNC_BYTE;
                        oValid <= 1'b1;
                        state  <= ST_HDR;
`ifdef TDC_PACK_SEQ_EN
                        seq_q  <= rdata[FW-1 -: 8];
`endif
                    end
                end
                ST_HDR: begin
                    if (iReady) begin
                        oByte <= sh[SH_W-1 -: 8];
                        sh    <= sh << 8;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (iReady) begin
                        if (idx == 3'd0) begin
`ifdef TDC_PACK_SEQ_EN
                            oByte  <= seq_q;
                            state  <= ST_SEQ;
`else
                            oValid <= 1'b0;
                            state  <= ST_IDLE;
`endif
                        end else begin
                            idx   <= idx - 3'd1;
                            oByte <= sh[SH_W-1 -: 8];
                            sh    <= sh << 8;
                        end
                    end
                end
                default: begin
                    // ST_SEQ: trailing sequence byte, then back to IDLE.
                    if (iReady) begin
                        oValid <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign oBusy = (state != ST_IDLE) || !empty;

endmodule

// File: tb/tb_tdc_result_packer.sv
// Randomised self-checking bench for tdc_result_packer (DATA_W=24, depth 16)
// against a queue-based model of words, frames and drop bookkeeping.
module tb_tdc_result_packer;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 16;
    localparam int NB     = 3;
`ifdef TDC_PACK_SEQ_EN
    localparam int FRAME_LEN = 2 + NB;
`else
    localparam int FRAME_LEN = 1 + NB;
`endif

    logic              iClk = 1'b0;
    logic              iRst = 1'b1;
    logic              iDone = 1'b0;
    logic [DATA_W-1:0] iTDC = '0;
    logic              iClrOvf = 1'b0;
    logic              iReady = 1'b0;
    logic [7:0]        oByte;
    logic              oValid;
    logic              oOverflow;
    logic [7:0]        oDropCnt;
    logic [4:0]        oLevel;
    logic              oBusy;

    tdc_result_packer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iDone     (iDone),
        .iTDC      (iTDC),
        .iClrOvf   (iClrOvf),
        .oByte     (oByte),
        .oValid    (oValid),
        .iReady    (iReady),
        .oOverflow (oOverflow),
        .oDropCnt  (oDropCnt),
        .oLevel    (oLevel),
        .oBusy     (oBusy)
    );

    always #5 iClk = ~iClk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: stored words, bytes still to send in the current
    // frame, the one-cycle input capture, and overflow bookkeeping.
    logic [31:0] m_fifo [$];
    logic [7:0]  m_frame [$];
    logic        m_done;
    logic [23:0] m_tdc;
    logic        m_ovf;
    int          m_cnt;
    logic [7:0]  m_seq;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_frame.delete();
        m_done = 1'b0;
        m_tdc  = '0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
        m_seq  = 8'd0;
    endtask

    // One clock edge of the model, using the inputs presented at that edge.
    task automatic model_step();
        bit          idle, pop, hs, acc, drp;
        logic [31:0] w;
        if (iRst) begin
            model_reset();
            return;
        end
        idle = (m_frame.size() == 0);
        pop  = idle && (m_fifo.size() > 0);
        hs   = !idle && iReady;
        acc  = m_done && ((m_fifo.size() < DEPTH) || pop);
        drp  = m_done && !acc;
        if (hs) void'(m_frame.pop_front());
        if (pop) begin
            w = m_fifo.pop_front();
            m_frame.push_back(8'hA5);
            for (int b = NB - 1; b >= 0; b--) m_frame.push_back(w[b*8 +: 8]);
`ifdef TDC_PACK_SEQ_EN
            m_frame.push_back(w[31:24]);
`endif
        end
        if (acc) begin
            m_fifo.push_back({m_seq, m_tdc});
            m_seq = m_seq + 8'd1;
        end
        if (iClrOvf) begin
            m_ovf = drp;
            m_cnt = drp ? 1 : 0;
        end else if (drp) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        m_done = iDone;
        m_tdc  = iTDC;
    endtask

    task automatic check_all();
        chk("valid", oValid, m_frame.size() > 0);
        if (m_frame.size() > 0) chk("byte", oByte, m_frame[0]);
        chk("level", oLevel, m_fifo.size());
        chk("ovf", oOverflow, m_ovf);
        chk("dropcnt", oDropCnt, m_cnt);
        chk("busy", oBusy, (m_frame.size() > 0) || (m_fifo.size() > 0));
    endtask

    task automatic cyc(input bit d, input logic [23:0] t, input bit r, input bit c);
        @(negedge iClk);
        iDone = d; iTDC = t; iReady = r; iClrOvf = c;
        @(posedge iClk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_valid", oValid, 0);
        chk("rst_byte", oByte, 0);
        chk("rst_ovf", oOverflow, 0);
        chk("rst_cnt", oDropCnt, 0);
        chk("rst_level", oLevel, 0);
        chk("rst_busy", oBusy, 0);
        repeat (2) cyc(0, 0, 1, 0);
        @(negedge iClk); iRst = 1'b0;

        // 1: single word, header two edges after the iDone edge
        cyc(1, 24'h123456, 1, 0);
        cyc(0, 0, 1, 0);
        chk("t1_pre", oValid, 0);
        cyc(0, 0, 1, 0);
        chk("t1_hdr", {oValid, oByte}, {1'b1, 8'hA5});
        repeat (FRAME_LEN + 2) cyc(0, 0, 1, 0);
        chk("t1_busy", oBusy, 0);
        chk("t1_level", oLevel, 0);

        // 2: backpressure while byte 34 is presented
        cyc(1, 24'h123456, 1, 0);
        repeat (4) cyc(0, 0, 1, 0);
        chk("t2_at34", oByte, 8'h34);
        repeat (5) begin
            cyc(0, 0, 0, 0);
            chk("t2_hold", {oValid, oByte}, {1'b1, 8'h34});
        end
        cyc(0, 0, 1, 0);
        chk("t2_next", oByte, 8'h56);
        repeat (FRAME_LEN + 2) cyc(0, 0, 1, 0);

        // 3: overflow; the first word is taken into the serialiser, so
        // 16 more fill the FIFO and the 18th is dropped
        repeat (18) cyc(1, 24'($urandom), 0, 0);
        cyc(0, 0, 0, 0);
        chk("t3_level", oLevel, 16);
        chk("t3_ovf", oOverflow, 1);
        chk("t3_cnt", oDropCnt, 1);
        cyc(0, 0, 0, 1);
        chk("t3_clr_ovf", oOverflow, 0);
        chk("t3_clr_cnt", oDropCnt, 0);

        // 4: push into a full FIFO on the edge the serialiser pops
        repeat (FRAME_LEN - 1) cyc(0, 0, 1, 0);
        cyc(1, 24'hC0FFEE, 1, 0);
        cyc(0, 0, 1, 0);
        chk("t4_level", oLevel, 16);
        chk("t4_ovf", oOverflow, 0);
        repeat (17 * (FRAME_LEN + 1) + 8) cyc(0, 0, 1, 0);
        chk("t4_drained", oBusy, 0);

        // drop counter saturation, then a clear colliding with a drop
        repeat (300) cyc(1, 24'($urandom), 0, 0);
        chk("sat_cnt", oDropCnt, 255);
        cyc(0, 0, 0, 1);
        chk("clr_drop_ovf", oOverflow, 1);
        chk("clr_drop_cnt", oDropCnt, 1);
        repeat (17 * (FRAME_LEN + 1) + 8) cyc(0, 0, 1, 0);

        // 5: async reset in the middle of the data bytes
        cyc(1, 24'h777777, 1, 0);
        repeat (4) cyc(0, 0, 1, 0);
        @(negedge iClk);
        iRst = 1'b1;
        model_reset();
        #1;
        chk("t5_valid", oValid, 0);
        check_all();
        repeat (2) cyc(0, 0, 1, 0);
        @(negedge iClk); iRst = 1'b0;
        cyc(1, 24'hABCDEF, 1, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < NB + 1; i++) begin
            cyc(0, 0, 1, 0);
            if (i == 1) chk("t5_byte1", oByte, 8'hAB);
            if (i == 3) chk("t5_byte3", oByte, 8'hEF);
        end
        repeat (4) cyc(0, 0, 1, 0);

        // 6: back-to-back results
        cyc(1, 24'h000001, 1, 0);
        cyc(1, 24'h000002, 1, 0);
        cyc(1, 24'h000003, 1, 0);
        repeat (3 * (FRAME_LEN + 1) + 4) cyc(0, 0, 1, 0);
        chk("t6_idle", oBusy, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(2) == 0), 24'($urandom),
                ($urandom_range(3) != 0), ($urandom_range(63) == 0));
        end
        repeat (17 * (FRAME_LEN + 1) + 8) cyc(0, 0, 1, 0);
        chk("end_idle", oBusy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
